// File: rtl/operand_stack_pkg.sv
// Shared definitions for the operand stack: op encoding and default geometry.
package operand_stack_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_BINOP = 3'd3,
        OP_DUP   = 3'd4,
        OP_SWAP  = 3'd5
    } op_e;

endpackage

// File: rtl/operand_stack_if.sv
// Operation/status bundle between a stack user (master) and the operand stack (slave).
interface operand_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             err;

    modport master (output op, din, input tos, nos, count, empty, full, err);
    modport slave  (input op, din, output tos, nos, count, empty, full, err);

endinterface

// File: rtl/operand_stack_mem.sv
// DEPTH x WIDTH register file: two write ports (port 1 wins on collision), two async read ports.
module operand_stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [WIDTH-1:0] wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [WIDTH-1:0] wd1,
    input  logic [AW-1:0]    ra0,
    output logic [WIDTH-1:0] rd0,
    input  logic [AW-1:0]    ra1,
    output logic [WIDTH-1:0] rd1
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (we0) mem[wa0] <= wd0;
            if (we1) mem[wa1] <= wd1;
        end
    end

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];

endmodule

// File: rtl/operand_stack.sv
// Operand stack: pointer/flag control around a two-write-port register file.
// Optional sticky illegal-operation flag enabled by defining OPERAND_STACK_ERR_EN.
module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    operand_stack_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]    cnt, cnt_nxt;
    logic [AW-1:0]    a_top, a_sec;
    logic [WIDTH-1:0] rd0, rd1, tos_w, nos_w;
    logic             is_empty, is_full, lt2;
    logic             we0, we1;
    logic [AW-1:0]    wa0, wa1;
    logic [WIDTH-1:0] wd0, wd1;

    // Address arithmetic wraps modulo DEPTH, which lands on the right slot even when cnt==DEPTH.
    assign a_top    = cnt[AW-1:0] - AW'(1);
    assign a_sec    = cnt[AW-1:0] - AW'(2);
    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CW'(DEPTH));
    assign lt2      = (cnt < CW'(2));
    assign tos_w    = is_empty ? '0 : rd0;
    assign nos_w    = lt2 ? '0 : rd1;

    always_comb begin
        cnt_nxt = cnt;
        we0     = 1'b0;
        wa0     = '0;
        wd0     = '0;
        we1     = 1'b0;
        wa1     = '0;
        wd1     = '0;
        case (bus.op)
            OP_PUSH: if (!is_full) begin
                we0 = 1'b1; wa0 = cnt[AW-1:0]; wd0 = bus.din; cnt_nxt = cnt + CW'(1);
            end
            OP_POP: if (!is_empty) cnt_nxt = cnt - CW'(1);
            OP_BINOP: if (!lt2) begin
                we0 = 1'b1; wa0 = a_sec; wd0 = bus.din; cnt_nxt = cnt - CW'(1);
            end
            OP_DUP: if (!is_full && !is_empty) begin
                we0 = 1'b1; wa0 = cnt[AW-1:0]; wd0 = tos_w; cnt_nxt = cnt + CW'(1);
            end
            OP_SWAP: if (!lt2) begin
                we0 = 1'b1; wa0 = a_top; wd0 = nos_w;
                we1 = 1'b1; wa1 = a_sec; wd1 = tos_w;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else        cnt <= cnt_nxt;
    end

    operand_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we0   (we0),
        .wa0   (wa0),
        .wd0   (wd0),
        .we1   (we1),
        .wa1   (wa1),
        .wd1   (wd1),
        .ra0   (a_top),
        .rd0   (rd0),
        .ra1   (a_sec),
        .rd1   (rd1)
    );

`ifdef OPERAND_STACK_ERR_EN
    logic illegal, err_q;

    always_comb begin
        illegal = 1'b0;
        case (bus.op)
            OP_PUSH:           illegal = is_full;
            OP_POP:            illegal = is_empty;
            OP_BINOP, OP_SWAP: illegal = lt2;
            OP_DUP:            illegal = is_full || is_empty;
            default:           illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       err_q <= 1'b0;
        else if (illegal) err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.tos   = tos_w;
    assign bus.nos   = nos_w;
    assign bus.count = cnt;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;

endmodule

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width.
REQ-002 SHALL have parameter DEPTH, default 16: number of stack entries, a power of two, minimum 4.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port op, input, 3 bits: operation code, sampled at the rising edge of clk.
REQ-006 SHALL have port din, input, WIDTH bits: operand for PUSH, or ALU result for BINOP.
REQ-007 SHALL have port tos, output, WIDTH bits: top-of-stack entry; drives the ALU in1 operand.
REQ-008 SHALL have port nos, output, WIDTH bits: next-of-stack entry; drives the ALU in2 operand.
REQ-009 SHALL have port count, output, log2(DEPTH)+1 bits: number of valid entries.
REQ-010 SHALL have ports empty and full, outputs, 1 bit each: empty=(count==0); full=(count==DEPTH).
REQ-011 SHALL have port err, output, 1 bit: sticky error flag (see Configuration).

Function
REQ-012 SHALL decode op as: 0 NOP, 1 PUSH, 2 POP, 3 BINOP, 4 DUP, 5 SWAP; codes 6-7 SHALL act as NOP.
REQ-013 PUSH SHALL write din to entry[count] and increment count.
REQ-014 POP SHALL decrement count; stored data is not cleared.
REQ-015 BINOP SHALL remove the top two entries and push din in one cycle: entry[count-2]=din, count decremented by 1.
REQ-016 DUP SHALL copy tos into entry[count] and increment count.
REQ-017 SWAP SHALL exchange entry[count-1] and entry[count-2]; count is unchanged.
REQ-018 Each operation SHALL take effect at the clock edge that samples it; tos, nos and count SHALL reflect the result in the following cycle; back-to-back operations every cycle SHALL be supported.
REQ-019 tos SHALL be combinational from storage: entry[count-1], or 0 when empty.
REQ-020 nos SHALL be combinational from storage: entry[count-2], or 0 when count<2.
REQ-021 An illegal operation SHALL leave all state unchanged; illegal operations are:
  - PUSH or DUP when full;
  - DUP or POP when empty;
  - BINOP or SWAP when count<2.
REQ-022 Data SHALL be stored as raw two's-complement bits with no arithmetic; for example, -2 is stored and read back as 8'hFE.
REQ-023 There SHALL be no wrap-around: count saturates at 0 and at DEPTH because of REQ-021.

Reset
REQ-024 While reset=0, asynchronously and without a clock edge:
  - count SHALL be 0, so empty=1, full=0, tos=0, nos=0;
  - err SHALL be 0;
  - all entries SHALL be 0.
REQ-025 Reset asserted mid-sequence SHALL discard all contents immediately.
REQ-026 The first operation SHALL be honoured at the first rising edge of clk after reset deasserts.

Configuration
REQ-027 With OPERAND_STACK_ERR_EN defined, any illegal operation (REQ-021) SHALL set err at that edge; err SHALL then hold 1 until reset.
REQ-028 Without OPERAND_STACK_ERR_EN, err SHALL be constant 0 and no error logic SHALL be synthesised; all other behaviour is identical.

Structure
REQ-029 A shared package operand_stack_pkg SHALL hold:
  - the op encoding enum (NOP, PUSH, POP, BINOP, DUP, SWAP);
  - default WIDTH and DEPTH constants.
REQ-030 The control FSM and ALU SHALL import operand_stack_pkg rather than redefine the codes.
REQ-031 Storage SHALL be one sub-module, operand_stack_mem, with DEPTH x WIDTH registers, two write ports and two read ports.
REQ-032 Pointer, flag and error logic SHALL reside in operand_stack.

Verification
REQ-033 Basic push: after reset, PUSH 3, then PUSH 6 -> tos=6, nos=3, count=2, empty=0.
REQ-034 Binary operation: from REQ-033, BINOP with din=9 -> count=1, tos=9, nos=0.
REQ-035 Negative data: PUSH 8'hFE, DUP, SWAP -> count=2, tos=nos=8'hFE; BINOP with din=8'hEE -> tos read as signed equals -18.
REQ-036 Full and overflow: 16 PUSHes of 1..16 -> full=1, tos=16; a 17th PUSH of 99 leaves tos=16, count=16; err=1 only with OPERAND_STACK_ERR_EN.
REQ-037 Underflow: from empty, POP, then BINOP, then SWAP -> count stays 0, tos=0; err per REQ-027/REQ-028.
REQ-038 Reset mid-operation: with count=5, pull reset low between clock edges -> count=0, empty=1, err=0 before the next edge; a PUSH 7 after release gives tos=7.
